bcd_rtc_alarm: RTL and testbench
================================

# bcd_rtc_alarm

Synchronous, parametrised BCD time-of-day counter with selectable 12/24-hour format, manual minute/hour adjustment, a programmable alarm and an hourly chime. Runs on one system clock and advances on a single-cycle 1 Hz enable pulse; no derived clocks or ripple carries. Sits between the 1 Hz tick divider and the display/buzzer drivers in the clock top level.

## Interface
- `MODE_12H`, 0 — 0: hours 00–23; 1: hours 12,01–11 with PM flag.
- `ALARM_LEN`, 60 — alarm duration in ticks (1–255).
- `CHIME_LEN`, 2 — chime duration in ticks (1–15).

- `CP` in 1 — system clock, rising edge.
- `nCR` in 1 — asynchronous active-low reset.
- `Tick` in 1 — 1 Hz enable, one CP cycle wide.
- `AdjMinKey` in 1 — level; minute adjust.
- `AdjHrKey` in 1 — level; hour adjust.
- `AlarmSet` in 1 — level; 1 = adjust keys target alarm registers instead of time.
- `AlarmEn` in 1 — level; alarm arm.
- `Hour`, `Minute`, `Second` out 8 — packed BCD time, tens in [7:4].
- `PM` out 1 — PM flag; constant 0 when `MODE_12H`=0.
- `AlarmHour`, `AlarmMinute` out 8 — BCD alarm setting; `AlarmPM` out 1.
- `Alarm` out 1 — buzzer request.
- `Chime` out 1 — hourly chime request.

## Operation
- All state changes only on CP edges where `Tick`=1, except `Alarm` clear on `AlarmEn`=0.
- Reset (24 h): time 00:00:00, alarm 00:00, PM=0. Reset (12 h): time 12:00:00, alarm 12:00, PM/AlarmPM=0. `Alarm`=0, `Chime`=0, internal tick counters 0.
- Seconds always count 00→59→00 on every tick.
- Normal mode (`AlarmSet`=0, keys low): seconds 59→00 carries to minutes; minutes 59→00 carries to hours.
- 24 h hours: 23→00. 12 h hours: 11→12 toggles PM; 12→01 no toggle.
- `AdjMinKey`=1, `AlarmSet`=0: minute +1 per tick, 59→00 without hour carry; second carry into minutes suppressed.
- `AdjHrKey`=1, `AlarmSet`=0: hour +1 per tick with the same wrap/PM rules; minute carry into hours suppressed.
- Both keys: both advance once per tick, independently.
- `AlarmSet`=1: keys advance `AlarmMinute`/`AlarmHour` (and `AlarmPM`) identically; time runs in normal mode.
- All BCD digits stay legal (tens ≤5 for min/sec; hours legal for the mode).
- Alarm trigger: on a tick where seconds roll 59→00 through normal counting (no time-adjust key active) and the new Hour:Minute (and PM) equal the alarm setting, with `AlarmEn`=1.
- `Alarm` stays high for `ALARM_LEN` ticks, then clears. `AlarmEn`=0 clears it at the next CP edge. A retrigger while high restarts the count.
- Chime: triggered when a normal carry takes Minute:Second 59:59→00:00 with no adjust key active. `Chime` is high for `CHIME_LEN` ticks.
- Reset mid-operation returns every register to its reset value immediately, independent of `CP`.

## Timing
- Time registers update on the CP edge that samples `Tick`=1 (latency 1 CP from Tick assertion).
- `Alarm` and `Chime` rise on the same edge on which the time registers take the matching value.
- Duration: `Alarm` falls on the edge that samples the `ALARM_LEN`-th Tick after the rising edge, giving exactly `ALARM_LEN` tick periods. `Chime` follows the same rule with `CHIME_LEN`.
- Key and `AlarmSet` levels are sampled only on tick edges. Changes between ticks have no effect.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- **Reset/basic count:** `MODE_12H`=0, release `nCR`, apply 3661 ticks.
  - Time reads 01:01:01; `Chime`=1 after tick 3600; `Chime`=0 after tick 3602.
- **24 h wrap:** from 23:59:58, apply 2 ticks.
  - Time 00:00:00; `Chime` pulses for 2 ticks.
- **12 h rollover:** `MODE_12H`=1, from 11:59:59 PM=0, apply 1 tick.
  - Time 12:00:00, PM=1.
  - From 12:59:59, 1 tick gives 01:00:00 with PM unchanged.
- **Adjust isolation:** time 10:59:30, hold `AdjMinKey` for 1 tick.
  - Time 10:00:31; hour unchanged; no `Chime`.
  - `AdjHrKey` at 23:xx for 1 tick gives hour 00 with minutes unchanged.
- **Alarm:** set alarm 07:30 via `AlarmSet`+keys, `AlarmEn`=1, run from 07:29:58.
  - `Alarm` rises on the edge showing 07:30:00 and falls after 60 ticks.
  - Repeat with `AlarmEn` dropped at tick 10: `Alarm` clears on the next CP edge.
- **Async reset mid-alarm:** assert `nCR` while `Alarm`=1 between CP edges.
  - All outputs are at their reset values immediately.

Source files
------------

// File: rtl/bcd_rtc_alarm_if.sv
// Control inputs and BCD time/alarm outputs of the time-of-day counter.
// The master drives the 1 Hz tick and keys; the slave is the counter itself.
interface bcd_rtc_alarm_if;
    logic       Tick;
    logic       AdjMinKey;
    logic       AdjHrKey;
    logic       AlarmSet;
    logic       AlarmEn;
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic       PM;
    logic [7:0] AlarmHour;
    logic [7:0] AlarmMinute;
    logic       AlarmPM;
    logic       Alarm;
    logic       Chime;

    modport master (
        output Tick, AdjMinKey, AdjHrKey, AlarmSet, AlarmEn,
        input  Hour, Minute, Second, PM, AlarmHour, AlarmMinute, AlarmPM, Alarm, Chime
    );

    modport slave (
        input  Tick, AdjMinKey, AdjHrKey, AlarmSet, AlarmEn,
        output Hour, Minute, Second, PM, AlarmHour, AlarmMinute, AlarmPM, Alarm, Chime
    );
endinterface

// File: rtl/bcd_rtc_alarm.sv
// BCD time-of-day counter with 12/24 h format, key adjustment, alarm and hourly chime.
// Everything advances only on the single-cycle 1 Hz Tick enable.
module bcd_rtc_alarm #(
    parameter bit          MODE_12H  = 1'b0,
    parameter int unsigned ALARM_LEN = 60,
    parameter int unsigned CHIME_LEN = 2
) (
    input  logic           i_CP,
    input  logic           i_nCR,
    bcd_rtc_alarm_if.slave rtc
);

    localparam logic [7:0] ALARM_LEN_C = ALARM_LEN[7:0];
    localparam logic [3:0] CHIME_LEN_C = CHIME_LEN[3:0];
    localparam logic [7:0] HOUR_RST    = MODE_12H ? 8'h12 : 8'h00;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Returns {pm, hour}; 12 h mode goes 11->12 with a PM toggle and 12->01 without.
    function automatic logic [8:0] inc_hour(input logic [7:0] h, input logic pm);
        logic [7:0] nh;
        logic       npm;
        nh  = (h[3:0] == 4'd9) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
        npm = pm;
        if (MODE_12H) begin
            if (h == 8'h12)
                nh = 8'h01;
            else if (h == 8'h11)
                npm = ~pm;
        end else if (h == 8'h23) begin
            nh = 8'h00;
        end
        return {npm, nh};
    endfunction

    logic [7:0] r_hour, r_min, r_sec, r_ahour, r_amin;
    logic       r_pm, r_apm, r_alarm, r_chime;
    logic [7:0] r_alarm_cnt;
    logic [3:0] r_chime_cnt;

    logic       w_tadj_min, w_tadj_hr, w_norm, w_sec_wrap, w_min_carry;
    logic [7:0] w_sec_next, w_min_next, w_hour_next;
    logic       w_pm_next, w_alarm_hit, w_chime_hit;
    logic [8:0] w_hour_inc, w_ahour_inc;

    always_comb begin
        w_tadj_min  = rtc.AdjMinKey & ~rtc.AlarmSet;
        w_tadj_hr   = rtc.AdjHrKey  & ~rtc.AlarmSet;
        w_norm      = ~(w_tadj_min | w_tadj_hr);
        w_sec_wrap  = (r_sec == 8'h59);
        w_sec_next  = inc60(r_sec);
        w_min_next  = r_min;
        if (w_tadj_min || w_sec_wrap)
            w_min_next = inc60(r_min);
        w_min_carry = w_sec_wrap & ~w_tadj_min & (r_min == 8'h59);
        w_hour_inc  = inc_hour(r_hour, r_pm);
        w_ahour_inc = inc_hour(r_ahour, r_apm);
        w_hour_next = r_hour;
        w_pm_next   = r_pm;
        // A held hour key and a minute carry on the same tick still step the hour only once.
        if (w_tadj_hr || w_min_carry) begin
            w_hour_next = w_hour_inc[7:0];
            w_pm_next   = w_hour_inc[8];
        end
        w_alarm_hit = w_sec_wrap & w_norm & rtc.AlarmEn &
                      (w_min_next == r_amin) & (w_hour_next == r_ahour) & (w_pm_next == r_apm);
        w_chime_hit = w_sec_wrap & w_norm & (r_min == 8'h59);
    end

    always_ff @(posedge i_CP or negedge i_nCR) begin
        if (!i_nCR) begin
            r_hour      <= HOUR_RST;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_pm        <= 1'b0;
            r_ahour     <= HOUR_RST;
            r_amin      <= 8'h00;
            r_apm       <= 1'b0;
            r_chime     <= 1'b0;
            r_chime_cnt <= 4'd0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= 8'd0;
        end else begin
            if (rtc.Tick) begin
                r_sec  <= w_sec_next;
                r_min  <= w_min_next;
                r_hour <= w_hour_next;
                r_pm   <= w_pm_next;
                if (rtc.AlarmSet && rtc.AdjMinKey)
                    r_amin <= inc60(r_amin);
                if (rtc.AlarmSet && rtc.AdjHrKey) begin
                    r_ahour <= w_ahour_inc[7:0];
                    r_apm   <= w_ahour_inc[8];
                end
                if (w_chime_hit) begin
                    r_chime     <= 1'b1;
                    r_chime_cnt <= CHIME_LEN_C;
                end else if (r_chime_cnt == 4'd1) begin
                    r_chime     <= 1'b0;
                    r_chime_cnt <= 4'd0;
                end else if (r_chime_cnt != 4'd0) begin
                    r_chime_cnt <= r_chime_cnt - 4'd1;
                end
            end
            // Disarming acts on any CP edge, not only on ticks.
            if (!rtc.AlarmEn) begin
                r_alarm     <= 1'b0;
                r_alarm_cnt <= 8'd0;
            end else if (rtc.Tick) begin
                if (w_alarm_hit) begin
                    r_alarm     <= 1'b1;
                    r_alarm_cnt <= ALARM_LEN_C;
                end else if (r_alarm_cnt == 8'd1) begin
                    r_alarm     <= 1'b0;
                    r_alarm_cnt <= 8'd0;
                end else if (r_alarm_cnt != 8'd0) begin
                    r_alarm_cnt <= r_alarm_cnt - 8'd1;
                end
            end
        end
    end

    assign rtc.Hour        = r_hour;
    assign rtc.Minute      = r_min;
    assign rtc.Second      = r_sec;
    assign rtc.PM          = MODE_12H ? r_pm : 1'b0;
    assign rtc.AlarmHour   = r_ahour;
    assign rtc.AlarmMinute = r_amin;
    assign rtc.AlarmPM     = MODE_12H ? r_apm : 1'b0;
    assign rtc.Alarm       = r_alarm;
    assign rtc.Chime       = r_chime;

endmodule

// File: tb/tb_bcd_rtc_alarm.sv
// Drives a 24 h and a 12 h instance with identical stimulus and compares both
// against a model that keeps time as plain integers (hour 0-23, minute, second).
module tb_bcd_rtc_alarm;
    localparam int ALEN = 60;
    localparam int CLEN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, kmin = 1'b0, khr = 1'b0, aset = 1'b0, aen = 1'b0;
    always #5 clk = ~clk;

    bcd_rtc_alarm_if if24();
    bcd_rtc_alarm_if if12();

    assign if24.Tick = tick;  assign if24.AdjMinKey = kmin; assign if24.AdjHrKey = khr;
    assign if24.AlarmSet = aset; assign if24.AlarmEn = aen;
    assign if12.Tick = tick;  assign if12.AdjMinKey = kmin; assign if12.AdjHrKey = khr;
    assign if12.AlarmSet = aset; assign if12.AlarmEn = aen;

    bcd_rtc_alarm #(.MODE_12H(1'b0), .ALARM_LEN(ALEN), .CHIME_LEN(CLEN)) dut24 (
        .i_CP(clk), .i_nCR(rst_n), .rtc(if24));
    bcd_rtc_alarm #(.MODE_12H(1'b1), .ALARM_LEN(ALEN), .CHIME_LEN(CLEN)) dut12 (
        .i_CP(clk), .i_nCR(rst_n), .rtc(if12));

    int n_err = 0, n_chk = 0;
    int h = 0, m = 0, s = 0, ah = 0, am = 0, alarm_left = 0, chime_left = 0;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    function automatic int disp_hour(input int hr, input bit m12);
        if (!m12) return hr;
        return (hr % 12 == 0) ? 12 : hr % 12;
    endfunction

    function automatic logic [43:0] expv(input bit m12);
        return {bcd(disp_hour(h, m12)), bcd(m), bcd(s), m12 && (h >= 12),
                bcd(disp_hour(ah, m12)), bcd(am), m12 && (ah >= 12),
                alarm_left > 0, chime_left > 0};
    endfunction

    function automatic logic [43:0] obsv(input bit m12);
        if (m12)
            return {if12.Hour, if12.Minute, if12.Second, if12.PM, if12.AlarmHour,
                    if12.AlarmMinute, if12.AlarmPM, if12.Alarm, if12.Chime};
        return {if24.Hour, if24.Minute, if24.Second, if24.PM, if24.AlarmHour,
                if24.AlarmMinute, if24.AlarmPM, if24.Alarm, if24.Chime};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/24h"}, 64'(obsv(1'b0)), 64'(expv(1'b0)));
        chk({tag, "/12h"}, 64'(obsv(1'b1)), 64'(expv(1'b1)));
    endtask

    // Reference behaviour for one CP edge, using the input levels sampled at that edge.
    task automatic model_edge();
        bit tmin, thr, norm, swrap, chm, trig;
        int nh, nm;
        trig = 1'b0;
        if (tick) begin
            tmin  = kmin && !aset;
            thr   = khr && !aset;
            norm  = !tmin && !thr;
            swrap = (s == 59);
            chm   = norm && swrap && (m == 59);
            nm    = (tmin || swrap) ? (m + 1) % 60 : m;
            nh    = (thr || (swrap && !tmin && m == 59)) ? (h + 1) % 24 : h;
            trig  = norm && swrap && aen && (nh == ah) && (nm == am);
            s = (s + 1) % 60; m = nm; h = nh;
            if (aset && kmin) am = (am + 1) % 60;
            if (aset && khr)  ah = (ah + 1) % 24;
            if (chm) chime_left = CLEN;
            else if (chime_left > 0) chime_left--;
        end
        if (!aen) alarm_left = 0;
        else if (tick) begin
            if (trig) alarm_left = ALEN;
            else if (alarm_left > 0) alarm_left--;
        end
    endtask

    task automatic cyc(input bit t, input bit mk, input bit hk, input bit as, input bit ae);
        @(negedge clk);
        tick = t; kmin = mk; khr = hk; aset = as; aen = ae;
        @(posedge clk);
        model_edge();
        #1 check_all("cycle");
        tick = 1'b0;
    endtask

    task automatic model_reset();
        h = 0; m = 0; s = 0; ah = 0; am = 0; alarm_left = 0; chime_left = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        tick = 1'b0; kmin = 1'b0; khr = 1'b0; aset = 1'b0;
        #1 model_reset();
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Reset, then steer the time to hh:mm:ss: hour key, plain ticks to line up (min - sec), minute key.
    task automatic goto(input int ht, input int mt, input int st);
        int dstar;
        do_reset();
        dstar = (mt - st + 60) % 60;
        while (h != ht) cyc(1, 0, 1, 0, aen);
        while ((m - s + 60) % 60 != dstar) cyc(1, 0, 0, 0, aen);
        while (m != mt) cyc(1, 1, 0, 0, aen);
    endtask

    task automatic set_alarm(input int aht, input int amt);
        while (ah != aht) cyc(1, 0, 1, 1, aen);
        while (am != amt) cyc(1, 1, 0, 1, aen);
    endtask

    initial begin
        aen = 1'b0;
        do_reset();
        $display("step reset: checks=%0d errors=%0d", n_chk, n_err);

        for (int i = 1; i <= 3661; i++) begin
            if (i % 7 == 0) cyc(0, 1, 1, 1, aen);
            cyc(1, 0, 0, 0, aen);
            if (i == 3600) chk("chime_rise", 64'(if24.Chime), 64'd1);
            if (i == 3601) chk("chime_hold", 64'(if24.Chime), 64'd1);
            if (i == 3602) chk("chime_fall", 64'(if24.Chime), 64'd0);
        end
        chk("t3661_hms", 64'({if24.Hour, if24.Minute, if24.Second}), 64'h010101);
        $display("step count3661: checks=%0d errors=%0d", n_chk, n_err);

        goto(23, 59, 58);
        cyc(1, 0, 0, 0, aen);
        cyc(1, 0, 0, 0, aen);
        chk("wrap24_hms", 64'({if24.Hour, if24.Minute, if24.Second}), 64'h000000);
        chk("wrap24_chime", 64'(if24.Chime), 64'd1);
        cyc(1, 0, 0, 0, aen);
        chk("wrap24_chime2", 64'(if24.Chime), 64'd1);
        cyc(1, 0, 0, 0, aen);
        chk("wrap24_chime_end", 64'(if24.Chime), 64'd0);
        $display("step wrap24: checks=%0d errors=%0d", n_chk, n_err);

        goto(11, 59, 59);
        cyc(1, 0, 0, 0, aen);
        chk("roll12_noon", 64'({if12.PM, if12.Hour, if12.Minute, if12.Second}), 64'h1120000);
        goto(12, 59, 59);
        cyc(1, 0, 0, 0, aen);
        chk("roll12_one", 64'({if12.PM, if12.Hour, if12.Minute, if12.Second}), 64'h1010000);
        $display("step roll12: checks=%0d errors=%0d", n_chk, n_err);

        goto(10, 59, 30);
        cyc(1, 1, 0, 0, aen);
        chk("adjmin_iso", 64'({if24.Hour, if24.Minute, if24.Second}), 64'h100031);
        chk("adjmin_nochime", 64'(if24.Chime), 64'd0);
        goto(23, 15, 0);
        cyc(1, 0, 1, 0, aen);
        chk("adjhr_wrap", 64'({if24.Hour, if24.Minute}), 64'h0015);
        $display("step adjust: checks=%0d errors=%0d", n_chk, n_err);

        aen = 1'b1;
        goto(7, 29, 21);
        set_alarm(7, 30);
        cyc(1, 0, 0, 0, aen);
        chk("alarm_pre", 64'(if24.Alarm), 64'd0);
        cyc(1, 0, 0, 0, aen);
        chk("alarm_rise", 64'({if24.Hour, if24.Minute, if24.Second, 7'd0, if24.Alarm}), 64'h07300001);
        for (int i = 1; i < ALEN; i++) cyc(1, 0, 0, 0, aen);
        chk("alarm_hold59", 64'(if24.Alarm), 64'd1);
        cyc(1, 0, 0, 0, aen);
        chk("alarm_fall60", 64'(if24.Alarm), 64'd0);
        $display("step alarm_len: checks=%0d errors=%0d", n_chk, n_err);

        goto(7, 29, 21);
        set_alarm(7, 30);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, aen);
        chk("alarm_on10", 64'(if12.Alarm), 64'd1);
        cyc(0, 0, 0, 0, 1'b0);
        chk("alarm_disarm", 64'({if24.Alarm, if12.Alarm}), 64'd0);
        $display("step alarm_disarm: checks=%0d errors=%0d", n_chk, n_err);

        aen = 1'b1;
        goto(7, 29, 21);
        set_alarm(7, 30);
        cyc(1, 0, 0, 0, aen);
        cyc(1, 0, 0, 0, aen);
        chk("alarm_before_rst", 64'(if24.Alarm), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_24", 64'(obsv(1'b0)), 64'd0);
        chk("async_rst_12", 64'(obsv(1'b1)),
            64'({8'h12, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0}));
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        $display("step async_reset: checks=%0d errors=%0d", n_chk, n_err);

        goto(5, 10, 0);
        set_alarm(5, 12);
        for (int i = 0; i < 3000; i++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++)
                cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), aen);
            if ($urandom_range(0, 63) == 0) aen = ~aen;
            cyc(1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, aen);
        end
        $display("step random: checks=%0d errors=%0d", n_chk, n_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
